keypad_scanner: RTL and testbench

//  4x4 matrix keypad front end for the calculator. Drives columns one-cold, samples rows,

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/scan_tick.sv | 30 +++
 rtl/keypad_scanner.sv | 173 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Holds the FSM state encoding, the matrix geometry and the column-drive helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    // Active-low one-cold column drive for column idx.
    function automatic logic [COLS-1:0] col_onecold(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running prescaler for the keypad scanner.
// Pulses tick for one clk every SCAN_DIV cycles; this pulse sets the column dwell time.
module scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: scans columns, debounces one key and reports it
// as a clean key_press level with a stable row*4+col key_code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DB_CNT   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_out,
    output logic             key_press,
    output logic [KEY_W-1:0] key_code
);

    localparam int CW = $clog2(DB_CNT + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CNT);

    logic            tick;
    logic [ROWS-1:0] row_meta_q;
    logic [ROWS-1:0] row_s_q;

    state_t          state_q,     state_d;
    logic [1:0]      col_q,       col_d;
    logic [1:0]      lrow_q,      lrow_d;
    logic [1:0]      lcol_q,      lcol_d;
    logic [CW-1:0]   db_q,        db_d;
    logic [CW-1:0]   rel_q,       rel_d;
    logic            key_press_q, key_press_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;

    logic            hit;
    logic [1:0]      hit_row;
    logic            row_low;
    logic [CW-1:0]   db_inc;
    logic [CW-1:0]   rel_inc;

    scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Rows are asynchronous to clk; only the second flop is ever looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= '1;
            row_s_q    <= '1;
        end else begin
            row_meta_q <= row_in;
            row_s_q    <= row_meta_q;
        end
    end

    // Lowest-index low row wins when several rows in the column are pressed.
    always_comb begin
        hit     = 1'b0;
        hit_row = 2'd0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_s_q[r]) begin
                hit     = 1'b1;
                hit_row = 2'(r);
            end
        end
        row_low = !row_s_q[lrow_q];
        db_inc  = db_q + CW'(1);
        rel_inc = rel_q + CW'(1);
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        lrow_d      = lrow_q;
        lcol_d      = lcol_q;
        db_d        = db_q;
        rel_d       = rel_q;
        key_press_d = key_press_q;
        key_code_d  = key_code_q;

        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (hit) begin
                        lrow_d = hit_row;
                        lcol_d = col_q;
                        db_d   = CW'(1);
                        if (DB_CNT == 1) begin
                            state_d     = HELD;
                            key_press_d = 1'b1;
                            key_code_d  = {hit_row, col_q};
                            db_d        = '0;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end

            DEBOUNCE: begin
                if (tick) begin
                    if (row_low) begin
                        if (db_inc == DB_MAX) begin
                            state_d     = HELD;
                            key_press_d = 1'b1;
                            key_code_d  = {lrow_q, lcol_q};
                            db_d        = '0;
                        end else begin
                            db_d = db_inc;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                        db_d    = '0;
                    end
                end
            end

            HELD: begin
                // Any low reading restarts the release count, so only a clean release ends the hold.
                if (tick) begin
                    if (!row_low) begin
                        if (rel_inc == DB_MAX) begin
                            state_d     = SCAN;
                            key_press_d = 1'b0;
                            col_d       = col_q + 2'd1;
                            rel_d       = '0;
                        end else begin
                            rel_d = rel_inc;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            lrow_q      <= 2'd0;
            lcol_q      <= 2'd0;
            db_q        <= '0;
            rel_q       <= '0;
            key_press_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            lrow_q      <= lrow_d;
            lcol_q      <= lcol_d;
            db_q        <= db_d;
            rel_q       <= rel_d;
            key_press_q <= key_press_d;
            key_code_q  <= key_code_d;
        end
    end

    assign col_out   = col_onecold(col_q);
    assign key_press = key_press_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the rows and
// a tick-level behavioural model of the scanner predicts column, key_press and key_code.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB_CNT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_press;
    logic [3:0]  key_code;

    logic [15:0] keys = '0;

    int checks = 0;
    int fails  = 0;

    int m_col;
    int m_locked;
    int m_row;
    int m_streak;
    int m_press;
    int m_code;
    int m_rel;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DB_CNT  (DB_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_press(key_press),
        .key_code (key_code)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low only while column c is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            if (keys[k] && (col_out[k % 4] == 1'b0)) begin
                row_in[k / 4] = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input int c, input bit down);
        keys[r * 4 + c] = down;
    endtask

    function automatic logic [3:0] expCol(input int c);
        logic [3:0] v;
        v    = 4'b1111;
        v[c] = 1'b0;
        return v;
    endfunction

    task automatic modelReset();
        m_col    = 0;
        m_locked = 0;
        m_row    = 0;
        m_streak = 0;
        m_press  = 0;
        m_code   = 0;
        m_rel    = 0;
    endtask

    // One scan tick of the reference: the keys seen are those under the column driven all dwell.
    task automatic modelTick();
        int hit_row;
        hit_row = -1;
        if (m_locked == 0) begin
            for (int r = 3; r >= 0; r--) begin
                if (keys[r * 4 + m_col]) hit_row = r;
            end
            if (hit_row >= 0) begin
                m_locked = 1;
                m_row    = hit_row;
                m_streak = 1;
                if (m_streak >= DB_CNT) begin
                    m_press = 1;
                    m_code  = m_row * 4 + m_col;
                    m_rel   = 0;
                end
            end else begin
                m_col = (m_col + 1) % 4;
            end
        end else if (m_press == 0) begin
            if (keys[m_row * 4 + m_col]) begin
                m_streak++;
                if (m_streak >= DB_CNT) begin
                    m_press = 1;
                    m_code  = m_row * 4 + m_col;
                    m_rel   = 0;
                end
            end else begin
                m_locked = 0;
                m_streak = 0;
                m_col    = (m_col + 1) % 4;
            end
        end else begin
            if (!keys[m_row * 4 + m_col]) begin
                m_rel++;
                if (m_rel >= DB_CNT) begin
                    m_press  = 0;
                    m_locked = 0;
                    m_rel    = 0;
                    m_col    = (m_col + 1) % 4;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (2) @(posedge clk);
            #1;
            checkOutput("col_dwell", {28'd0, col_out}, {28'd0, expCol(m_col)});
            repeat (SCAN_DIV - 2) @(posedge clk);
            modelTick();
            #1;
            checkOutput("col_out", {28'd0, col_out}, {28'd0, expCol(m_col)});
            checkOutput("key_press", {31'd0, key_press}, 32'(m_press));
            checkOutput("key_code", {28'd0, key_code}, 32'(m_code));
        end
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        checkOutput("rst_press", {31'd0, key_press}, 32'd0);
        checkOutput("rst_col", {28'd0, col_out}, 32'hE);
        checkOutput("rst_code", {28'd0, key_code}, 32'd0);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        int r;
        int c;
        int n_down;
        modelReset();

        $display("[TB] reset and idle scan");
        doReset(2);
        runTicks(5);

        $display("[TB] press and release key (2,1)");
        applyStimulus(2, 1, 1'b1);
        runTicks(10);
        checkOutput("t2_press", {31'd0, key_press}, 32'd1);
        checkOutput("t2_code", {28'd0, key_code}, 32'h9);
        checkOutput("t2_col", {28'd0, col_out}, 32'hD);
        applyStimulus(2, 1, 1'b0);
        runTicks(2);
        checkOutput("t2_still_held", {31'd0, key_press}, 32'd1);
        runTicks(1);
        checkOutput("t2_released", {31'd0, key_press}, 32'd0);
        checkOutput("t2_next_col", {28'd0, col_out}, 32'hB);

        $display("[TB] single-tick bounce on (0,3)");
        for (int k = 0; k < 4 && m_col != 3; k++) runTicks(1);
        applyStimulus(0, 3, 1'b1);
        runTicks(1);
        applyStimulus(0, 3, 1'b0);
        runTicks(1);
        checkOutput("t3_no_press", {31'd0, key_press}, 32'd0);
        checkOutput("t3_col_wrap", {28'd0, col_out}, 32'hE);

        $display("[TB] hold (1,0), add (3,2), release (1,0)");
        applyStimulus(1, 0, 1'b1);
        runTicks(10);
        applyStimulus(3, 2, 1'b1);
        runTicks(5);
        checkOutput("t4_code_held", {28'd0, key_code}, 32'h4);
        applyStimulus(1, 0, 1'b0);
        runTicks(10);
        checkOutput("t4_press_e", {31'd0, key_press}, 32'd1);
        checkOutput("t4_code_e", {28'd0, key_code}, 32'hE);
        applyStimulus(3, 2, 1'b0);
        runTicks(4);

        $display("[TB] same column (1,2) and (3,2)");
        applyStimulus(1, 2, 1'b1);
        applyStimulus(3, 2, 1'b1);
        runTicks(10);
        checkOutput("t5_code", {28'd0, key_code}, 32'h6);
        applyStimulus(1, 2, 1'b0);
        applyStimulus(3, 2, 1'b0);
        runTicks(4);

        $display("[TB] reset while key (2,0) held");
        applyStimulus(2, 0, 1'b1);
        runTicks(10);
        checkOutput("t6_held", {31'd0, key_press}, 32'd1);
        doReset(1);
        runTicks(2);
        checkOutput("t6_not_yet", {31'd0, key_press}, 32'd0);
        runTicks(1);
        checkOutput("t6_redetect", {31'd0, key_press}, 32'd1);
        checkOutput("t6_code", {28'd0, key_code}, 32'h8);
        applyStimulus(2, 0, 1'b0);
        runTicks(4);

        $display("[TB] randomized key activity");
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, 3));
                c = int'($urandom_range(0, 3));
                n_down = $countones(keys);
                if (!keys[r * 4 + c] && n_down >= 2) begin
                    keys = '0;
                end else begin
                    applyStimulus(r, c, !keys[r * 4 + c]);
                end
            end
            runTicks(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
